controlador_puertas: RTL
========================

Name: controlador_puertas

Overview:
Synchronous door sequencer for the elevator cabin. It drives the door motor and owns the 2-bit door state (00 closed, 01 open, 10 opening, 11 closing). It counts the open-dwell time and the motor-travel time with cycle counters, and generates the door timeout itself. Sits between the floor/cabin controller (requests, interlock) and the door motor and limit switches.

Parameters:
T_ABIERTA, 100, cycles the doors stay open before auto-close (>=2)
T_MOTOR, 50, max cycles a motor may run before its limit switch is reached (>=2)
ANCHO, 8, counter width; must hold max(T_ABIERTA, T_MOTOR)-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
abrir  in  1  open request (level) from cabin controller or button
cerrar  in  1  close-now button (level)
en_piso  in  1  cabin stopped and levelled at a floor
obstaculo  in  1  door-edge sensor, 1 = blocked
fin_abrir  in  1  fully-open limit switch
fin_cerrar  in  1  fully-closed limit switch
estado  out  2  door state: 00 CERRADA, 01 ABIERTA, 10 ABRIENDO, 11 CERRANDO
motor_abrir  out  1  drive motor in open direction
motor_cerrar  out  1  drive motor in close direction
timeout  out  1  one-cycle pulse: open dwell expired
puertas_cerradas  out  1  interlock to cabin controller, 1 = safe to move
falla  out  1  sticky fault flag

Behaviour:
- All outputs registered. Clock and reset are fixed: one clock, reset synchronous and active-high.
- Reset values: estado=00, cnt=0, motor_abrir=0, motor_cerrar=0, timeout=0, falla=0, puertas_cerradas=1.
- Reset applied in any state or mid-motion returns to these values on the next edge.
- motor_abrir=1 iff estado=ABRIENDO and falla=0.
- motor_cerrar=1 iff estado=CERRANDO and falla=0.
- puertas_cerradas=1 iff estado=CERRADA and falla=0.
- Each state change clears cnt. Otherwise cnt increments each cycle and saturates at all-ones.
- CERRADA:
  - abrir=1 and en_piso=1 -> ABRIENDO.
  - abrir without en_piso is ignored.
- ABRIENDO:
  - fin_abrir=1 -> ABIERTA.
  - Else cnt==T_MOTOR-1 -> falla.
- ABIERTA, priority from highest:
  - obstaculo=1 or abrir=1: stay, cnt cleared (dwell restarts).
  - cerrar=1 -> CERRANDO, no timeout pulse.
  - cnt==T_ABIERTA-1 -> CERRANDO, with timeout=1 in the first CERRANDO cycle only.
  - Result: an undisturbed ABIERTA lasts exactly T_ABIERTA cycles.
- CERRANDO, priority from highest:
  - obstaculo=1 or abrir=1 -> ABRIENDO (reopen). This wins over a simultaneous fin_cerrar.
  - fin_cerrar=1 -> CERRADA.
  - cnt==T_MOTOR-1 -> falla.
- Sensor inconsistency: fin_abrir=1 and fin_cerrar=1 in the same cycle, in any state -> falla.
- Fault handling:
  - On fault: falla=1 next cycle, estado forced to ABIERTA (doors not proven closed), both motors 0, timeout 0.
  - While falla=1, all inputs are ignored and only reset clears it.
- timeout is never asserted in any cycle other than the one defined above.

Test Plan:
Params T_ABIERTA=8, T_MOTOR=5 for all scenarios.
1. Normal cycle: reset, en_piso=1, abrir pulse 1 cycle -> estado=10 with motor_abrir=1. fin_abrir at 3rd ABRIENDO cycle -> estado=01 for exactly 8 cycles, then estado=11 with timeout=1 for 1 cycle. fin_cerrar -> estado=00, puertas_cerradas=1.
2. Dwell restart: in ABIERTA at cnt=5, obstaculo=1 for 1 cycle -> ABIERTA lasts 8 more cycles after obstaculo drops. abrir held -> never times out.
3. Reopen and priority: in CERRANDO, obstaculo=1 and fin_cerrar=1 in the same cycle -> estado=10, motor_abrir=1, timeout=0. cerrar=1 in ABIERTA -> CERRANDO next cycle, timeout stays 0.
4. Interlock: abrir=1 with en_piso=0 in CERRADA for 20 cycles -> estado stays 00, motors 0, puertas_cerradas=1.
5. Motor stall: in ABRIENDO, fin_abrir held 0 -> after 5 cycles falla=1, estado=01, motors 0. Further abrir/cerrar ignored; reset -> all outputs at reset values.
6. Sensor fault and reset mid-motion: fin_abrir=fin_cerrar=1 while CERRADA -> falla=1 next cycle. Separately, reset asserted during CERRANDO -> estado=00, motor_cerrar=0 on the next edge.

Source files
------------

// File: rtl/controlador_puertas.sv
// Elevator door sequencer: drives the door motor, times the open dwell and motor
// travel with one cycle counter, and latches a sticky fault on stall or bad sensors.
module controlador_puertas #(
    parameter int unsigned T_ABIERTA = 100,
    parameter int unsigned T_MOTOR   = 50,
    parameter int unsigned ANCHO     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       abrir,
    input  logic       cerrar,
    input  logic       en_piso,
    input  logic       obstaculo,
    input  logic       fin_abrir,
    input  logic       fin_cerrar,
    output logic [1:0] estado,
    output logic       motor_abrir,
    output logic       motor_cerrar,
    output logic       timeout,
    output logic       puertas_cerradas,
    output logic       falla
);

    typedef enum logic [1:0] {
        CERRADA  = 2'b00,
        ABIERTA  = 2'b01,
        ABRIENDO = 2'b10,
        CERRANDO = 2'b11
    } estado_t;

    localparam logic [ANCHO-1:0] FIN_DWELL = ANCHO'(T_ABIERTA - 1);
    localparam logic [ANCHO-1:0] FIN_MOTOR = ANCHO'(T_MOTOR - 1);
    localparam logic [ANCHO-1:0] CNT_MAX   = '1;

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] cnt_q, cnt_d;
    logic             falla_q, falla_d;
    logic             timeout_q, timeout_d;
    logic             motor_abrir_q, motor_abrir_d;
    logic             motor_cerrar_q, motor_cerrar_d;
    logic             puertas_cerradas_q, puertas_cerradas_d;
    logic             cnt_clr;

    // Next-state logic; a fault freezes everything until reset.
    always_comb begin
        estado_d  = estado_q;
        falla_d   = falla_q;
        timeout_d = 1'b0;
        cnt_clr   = 1'b0;

        if (!falla_q) begin
            if (fin_abrir && fin_cerrar) begin
                falla_d = 1'b1;
            end else begin
                unique case (estado_q)
                    CERRADA: begin
                        if (abrir && en_piso) begin
                            estado_d = ABRIENDO;
                        end
                    end
                    ABRIENDO: begin
                        if (fin_abrir) begin
                            estado_d = ABIERTA;
                        end else if (cnt_q == FIN_MOTOR) begin
                            falla_d = 1'b1;
                        end
                    end
                    ABIERTA: begin
                        if (obstaculo || abrir) begin
                            cnt_clr = 1'b1;
                        end else if (cerrar) begin
                            estado_d = CERRANDO;
                        end else if (cnt_q == FIN_DWELL) begin
                            estado_d  = CERRANDO;
                            timeout_d = 1'b1;
                        end
                    end
                    CERRANDO: begin
                        if (obstaculo || abrir) begin
                            estado_d = ABRIENDO;
                        end else if (fin_cerrar) begin
                            estado_d = CERRADA;
                        end else if (cnt_q == FIN_MOTOR) begin
                            falla_d = 1'b1;
                        end
                    end
                    default: estado_d = CERRADA;
                endcase
            end
        end

        // Doors are not proven closed after a fault, so report them open.
        if (falla_d && !falla_q) begin
            estado_d  = ABIERTA;
            timeout_d = 1'b0;
        end

        if (falla_q) begin
            cnt_d = cnt_q;
        end else if (cnt_clr || (estado_d != estado_q) || falla_d) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + ANCHO'(1);
        end else begin
            cnt_d = cnt_q;
        end

        motor_abrir_d      = (estado_d == ABRIENDO) && !falla_d;
        motor_cerrar_d     = (estado_d == CERRANDO) && !falla_d;
        puertas_cerradas_d = (estado_d == CERRADA) && !falla_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q           <= CERRADA;
            cnt_q              <= '0;
            falla_q            <= 1'b0;
            timeout_q          <= 1'b0;
            motor_abrir_q      <= 1'b0;
            motor_cerrar_q     <= 1'b0;
            puertas_cerradas_q <= 1'b1;
        end else begin
            estado_q           <= estado_d;
            cnt_q              <= cnt_d;
            falla_q            <= falla_d;
            timeout_q          <= timeout_d;
            motor_abrir_q      <= motor_abrir_d;
            motor_cerrar_q     <= motor_cerrar_d;
            puertas_cerradas_q <= puertas_cerradas_d;
        end
    end

    assign estado           = estado_q;
    assign motor_abrir      = motor_abrir_q;
    assign motor_cerrar     = motor_cerrar_q;
    assign timeout          = timeout_q;
    assign puertas_cerradas = puertas_cerradas_q;
    assign falla            = falla_q;

endmodule
